// File: rtl/dht11_pkg.sv
// Shared DHT11 reader definitions: FSM state codes, error causes, default protocol timing
// and the frame checksum helper.
package dht11_pkg;

  localparam int unsigned DHT11_CLK_HZ        = 100_000_000;
  localparam int unsigned DHT11_START_LOW_US  = 18_000;
  localparam int unsigned DHT11_TIMEOUT_US    = 200;
  localparam int unsigned DHT11_BIT_THRESH_US = 50;
  localparam int unsigned DHT11_FRAME_BITS    = 40;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_START_LOW = 3'd1;
  localparam logic [2:0] S_RELEASE   = 3'd2;
  localparam logic [2:0] S_RESP_LOW  = 3'd3;
  localparam logic [2:0] S_RESP_HIGH = 3'd4;
  localparam logic [2:0] S_BIT_LOW   = 3'd5;
  localparam logic [2:0] S_BIT_HIGH  = 3'd6;
  localparam logic [2:0] S_CHECK     = 3'd7;

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b01;
  localparam logic [1:0] ERR_CHECKSUM = 2'b10;
  localparam logic [1:0] ERR_STUCK    = 2'b11;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Frame layout MSB-first: {RH int, RH dec, T int, T dec, checksum}.
  function automatic logic checksum_ok(input logic [39:0] frame);
    logic [7:0] sum;
    sum = frame[39:32] + frame[31:24] + frame[23:16] + frame[15:8];
    return sum == frame[7:0];
  endfunction

endpackage

// File: rtl/usec_tick.sv
// Free-running divider: tick is high for one clk in every CLK_HZ/1e6 clocks (always high at 1 MHz).
// No handshake; the tick is consumed by whoever samples it in that cycle.
module usec_tick
  import dht11_pkg::*;
#(
  parameter int unsigned CLK_HZ = DHT11_CLK_HZ
) (
  input  logic clk,
  input  logic reset_n,
  output logic tick
);

  localparam int unsigned DIV  = (CLK_HZ >= 1_000_000) ? CLK_HZ / 1_000_000 : 1;
  localparam int unsigned CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/dht11_frame_reader.sv
// DHT11 reader: host start pulse, response handshake, 40-bit capture; result 1 clk after the last bit.
// start is ignored while busy or during the valid/error cycle; DHT11_CHECKSUM_EN compiles in the checksum compare.
module dht11_frame_reader
  import dht11_pkg::*;
#(
  parameter int unsigned CLK_HZ        = DHT11_CLK_HZ,
  parameter int unsigned START_LOW_US  = DHT11_START_LOW_US,
  parameter int unsigned TIMEOUT_US    = DHT11_TIMEOUT_US,
  parameter int unsigned BIT_THRESH_US = DHT11_BIT_THRESH_US
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  inout  wire         dht11_data,
  output logic        busy,
  output logic        valid,
  output logic        error,
  output logic [1:0]  err_code,
  output logic [7:0]  humidity,
  output logic [7:0]  temperature,
  output logic [15:0] value
);

  localparam int unsigned CNT_W =
    $clog2(max3(START_LOW_US, TIMEOUT_US, BIT_THRESH_US) + 1) + 1;
  localparam logic [CNT_W-1:0] START_LAST   = CNT_W'(START_LOW_US - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_US - 1);
  localparam logic [CNT_W-1:0] BIT_THRESH   = CNT_W'(BIT_THRESH_US);
  localparam logic [5:0]       BIT_LAST     = 6'(DHT11_FRAME_BITS - 1);

  logic             tick;
  logic [2:0]       state;
  logic             sync_q1, sync_q2, line_d;
  logic             rise, fall;
  logic [CNT_W-1:0] us_cnt;
  logic [5:0]       bit_cnt;
  logic [39:0]      shift;
  logic [2:0]       phase_next;
  logic             want_rise;
  logic             edge_hit;
  logic             last_bit;
  logic             bit_val;
  logic             timed_out;
  logic             sum_ok;

  usec_tick #(
    .CLK_HZ (CLK_HZ)
  ) u_tick (
    .clk     (clk),
    .reset_n (reset_n),
    .tick    (tick)
  );

  // Open-drain: only ever pull low, and only while issuing the start pulse.
  assign dht11_data = (state == S_START_LOW) ? 1'b0 : 1'bz;

  // Synchronizers reset high so an idle pulled-up line produces no edge after reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q1 <= 1'b1;
      sync_q2 <= 1'b1;
      line_d  <= 1'b1;
    end else begin
      sync_q1 <= dht11_data;
      sync_q2 <= sync_q1;
      line_d  <= sync_q2;
    end
  end

  assign rise = sync_q2 & ~line_d;
  assign fall = ~sync_q2 & line_d;

  always_comb begin
    phase_next = S_IDLE;
    want_rise  = 1'b0;
    case (state)
      S_RELEASE:   phase_next = S_RESP_LOW;
      S_RESP_LOW:  begin phase_next = S_RESP_HIGH; want_rise = 1'b1; end
      S_RESP_HIGH: phase_next = S_BIT_LOW;
      S_BIT_LOW:   begin phase_next = S_BIT_HIGH;  want_rise = 1'b1; end
      S_BIT_HIGH:  phase_next = last_bit ? S_CHECK : S_BIT_LOW;
      default:     phase_next = S_IDLE;
    endcase
  end

  assign edge_hit  = want_rise ? rise : fall;
  assign last_bit  = (bit_cnt == BIT_LAST);
  assign bit_val   = (us_cnt > BIT_THRESH);
  assign timed_out = tick && (us_cnt == TIMEOUT_LAST);
  assign sum_ok    = checksum_ok(shift);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      us_cnt      <= '0;
      bit_cnt     <= '0;
      shift       <= '0;
      valid       <= 1'b0;
      error       <= 1'b0;
      err_code    <= ERR_NONE;
      humidity    <= '0;
      temperature <= '0;
    end else begin
      valid <= 1'b0;
      error <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start && !valid && !error) begin
            us_cnt  <= '0;
            bit_cnt <= '0;
            if (sync_q2) begin
              state <= S_START_LOW;
            end else begin
              error    <= 1'b1;
              err_code <= ERR_STUCK;
            end
          end
        end

        S_START_LOW: begin
          if (tick) begin
            if (us_cnt == START_LAST) begin
              state  <= S_RELEASE;
              us_cnt <= '0;
            end else begin
              us_cnt <= us_cnt + 1'b1;
            end
          end
        end

        S_RELEASE, S_RESP_LOW, S_RESP_HIGH, S_BIT_LOW, S_BIT_HIGH: begin
          if (edge_hit) begin
            state  <= phase_next;
            us_cnt <= '0;
            if (state == S_BIT_HIGH) begin
              shift   <= {shift[38:0], bit_val};
              bit_cnt <= bit_cnt + 6'd1;
            end
          end else if (timed_out) begin
            us_cnt <= '0;
            // A sensor that never pulls low after the last bit still delivered a complete frame.
            if (state == S_BIT_HIGH && last_bit) begin
              shift   <= {shift[38:0], bit_val};
              bit_cnt <= bit_cnt + 6'd1;
              state   <= S_CHECK;
            end else begin
              state    <= S_IDLE;
              error    <= 1'b1;
              err_code <= ERR_TIMEOUT;
            end
          end else if (tick) begin
            us_cnt <= us_cnt + 1'b1;
          end
        end

        S_CHECK: begin
          state   <= S_IDLE;
          bit_cnt <= '0;
`ifdef DHT11_CHECKSUM_EN
          if (sum_ok) begin
            humidity    <= shift[39:32];
            temperature <= shift[23:16];
            valid       <= 1'b1;
          end else begin
            error    <= 1'b1;
            err_code <= ERR_CHECKSUM;
          end
`else
          humidity    <= shift[39:32];
          temperature <= shift[23:16];
          valid       <= 1'b1;
`endif
        end

        default: state <= S_IDLE;
      endcase
    end
  end

`ifndef DHT11_CHECKSUM_EN
  logic unused_sum_ok;
  assign unused_sum_ok = sum_ok;
`endif

  assign busy  = (state != S_IDLE);
  assign value = {humidity, temperature};

endmodule

// File: tb/tb_dht11_frame_reader.sv
// Bench for dht11_frame_reader at 1 MHz: a sensor model drives frames, a scoreboard queue holds
// the expected valid/error events and a negedge monitor pops and compares them.
module tb_dht11_frame_reader;

  localparam int unsigned CLK_HZ        = 1_000_000;
  localparam int unsigned START_LOW_US  = 100;
  localparam int unsigned TIMEOUT_US    = 200;
  localparam int unsigned BIT_THRESH_US = 50;
  // 2-flop synchronizer + edge register + one cycle in CHECK, counted from the line falling.
  localparam int          FRAME_LAT     = 4;

  logic        clk        = 1'b0;
  logic        reset_n    = 1'b1;
  logic        start      = 1'b0;
  logic        sensor_low = 1'b0;
  wire         dht11_data;
  logic        busy, valid, error;
  logic [1:0]  err_code;
  logic [7:0]  humidity, temperature;
  logic [15:0] value;

  pullup (dht11_data);
  assign dht11_data = sensor_low ? 1'b0 : 1'bz;

  dht11_frame_reader #(
    .CLK_HZ        (CLK_HZ),
    .START_LOW_US  (START_LOW_US),
    .TIMEOUT_US    (TIMEOUT_US),
    .BIT_THRESH_US (BIT_THRESH_US)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .dht11_data  (dht11_data),
    .busy        (busy),
    .valid       (valid),
    .error       (error),
    .err_code    (err_code),
    .humidity    (humidity),
    .temperature (temperature),
    .value       (value)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_err;
    logic [1:0]  code;
    logic [15:0] val;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          checks   = 0;
  int          failures = 0;
  int          cyc      = 0;
  int          ref_cyc  = 0;
  logic [15:0] model_value = 16'h0000;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Reference model: checksum is the byte-wise sum of RH/T bytes modulo 256.
  function automatic exp_t frame_expect(input logic [39:0] f);
    exp_t e;
    e.lat = FRAME_LAT;
`ifdef DHT11_CHECKSUM_EN
    begin
      int sum;
      sum = (int'(f[39:32]) + int'(f[31:24]) + int'(f[23:16]) + int'(f[15:8])) % 256;
      if (sum != int'(f[7:0])) begin
        e.is_err = 1'b1;
        e.code   = 2'b10;
        e.val    = model_value;
        return e;
      end
    end
`endif
    e.is_err    = 1'b0;
    e.code      = 2'b00;
    e.val       = {f[39:32], f[23:16]};
    model_value = e.val;
    return e;
  endfunction

  function automatic exp_t err_expect(input logic [1:0] code, input int lat);
    exp_t e;
    e.is_err = 1'b1;
    e.code   = code;
    e.val    = model_value;
    e.lat    = lat;
    return e;
  endfunction

  function automatic logic [39:0] rand_frame(input bit good);
    logic [7:0] b4, b3, b2, b1, b0;
    b4 = 8'($urandom);
    b3 = 8'($urandom);
    b2 = 8'($urandom);
    b1 = 8'($urandom);
    b0 = b4 + b3 + b2 + b1;
    if (!good) b0 = b0 + 8'($urandom_range(255, 1));
    return {b4, b3, b2, b1, b0};
  endfunction

  always @(negedge clk) begin
    if (reset_n && (valid || error)) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_pulse: valid=%0b error=%0b with nothing outstanding (cycle %0d)",
                 valid, error, cyc);
      end else begin
        mon_e = sb.pop_front();
        check("pulse_exclusive", valid & error, 0);
        check("pulse_kind", error, mon_e.is_err);
        if (mon_e.is_err) begin
          check("err_code", err_code, mon_e.code);
        end else begin
          check("humidity", humidity, mon_e.val[15:8]);
          check("temperature", temperature, mon_e.val[7:0]);
        end
        check("value", value, mon_e.val);
        check("latency", cyc - ref_cyc, mon_e.lat);
        check("busy_at_pulse", busy, 0);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Host start: returns the cycle at which the line was first seen released.
  task automatic host_start(output int rel_cyc);
    int low_cnt;
    start = 1'b1;
    idle(1);
    start = 1'b0;
    check("busy_after_start", busy, 1);
    low_cnt = 0;
    while (dht11_data === 1'b0 && low_cnt <= int'(START_LOW_US) + 20) begin
      low_cnt++;
      idle(1);
    end
    check("start_low_width", low_cnt, START_LOW_US);
    rel_cyc = cyc;
  endtask

  task automatic reset_pulse_check();
    reset_n = 1'b0;
    #1;
    check("rst_busy", busy, 0);
    check("rst_valid", valid, 0);
    check("rst_error", error, 0);
    check("rst_err_code", err_code, 0);
    check("rst_humidity", humidity, 0);
    check("rst_temperature", temperature, 0);
    check("rst_value", value, 0);
    check("rst_line", dht11_data, 1);
    model_value = 16'h0000;
    idle(3);
    reset_n = 1'b1;
    idle(3);
  endtask

  task automatic sensor_frame(input logic [39:0] f, input int abort_bit, input int poke_bit,
                              input bit hit_valid);
    int w;
    idle(20);
    sensor_low = 1'b1;
    idle(80);
    sensor_low = 1'b0;
    idle(80);
    for (int i = 0; i < 40; i++) begin
      sensor_low = 1'b1;
      if (i == poke_bit) start = 1'b1;
      idle(1);
      start = 1'b0;
      idle(int'($urandom_range(54, 44)));
      sensor_low = 1'b0;
      if (i == abort_bit) begin
        idle(10);
        reset_pulse_check();
        return;
      end
      idle(f[39 - i] ? int'($urandom_range(75, 65)) : int'($urandom_range(30, 22)));
    end
    sensor_low = 1'b1;
    ref_cyc    = cyc;
    w          = 0;
    if (hit_valid) begin
      while (!valid && w < 10) begin
        idle(1);
        w++;
      end
      check("valid_seen", valid, 1);
      start = 1'b1;
      idle(1);
      start = 1'b0;
      check("start_in_valid_cycle_ignored", busy, 0);
      w = w + 1;
    end
    idle(50 - w);
    sensor_low = 1'b0;
    idle(5);
    check("line_released_after_frame", dht11_data, 1);
    check("busy_after_frame", busy, 0);
  endtask

  initial begin
    repeat (150000) @(posedge clk);
    $display("FAIL watchdog: run exceeded 150000 cycles");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [39:0] f;
    int          rc;

    #1 reset_n = 1'b0;
    idle(5);
    check("reset_busy", busy, 0);
    check("reset_valid", valid, 0);
    check("reset_error", error, 0);
    check("reset_err_code", err_code, 0);
    check("reset_value", value, 0);
    check("reset_line", dht11_data, 1);
    reset_n = 1'b1;
    idle(5);

    // Reference frame: RH 0x37, T 0x19, checksum 0x50.
    f = 40'h37_00_19_00_50;
    sb.push_back(frame_expect(f));
    host_start(rc);
    sensor_frame(f, -1, -1, 1'b0);
    idle(20);

    // Same frame with a corrupted checksum byte.
    f = 40'h37_00_19_00_51;
    sb.push_back(frame_expect(f));
    host_start(rc);
    sensor_frame(f, -1, -1, 1'b0);
    idle(20);

    // Sensor silent after release.
    sb.push_back(err_expect(2'b01, TIMEOUT_US));
    host_start(rc);
    ref_cyc = rc;
    idle(int'(TIMEOUT_US) - 10);
    check("busy_before_timeout", busy, 1);
    idle(20);
    check("busy_after_timeout", busy, 0);
    check("line_after_timeout", dht11_data, 1);
    idle(10);

    // Line held low by the sensor when start arrives.
    sensor_low = 1'b1;
    idle(5);
    sb.push_back(err_expect(2'b11, 1));
    ref_cyc = cyc;
    start   = 1'b1;
    idle(1);
    start = 1'b0;
    check("busy_stuck_start", busy, 0);
    idle(3);
    sensor_low = 1'b0;
    idle(4);
    check("line_not_driven_after_stuck", dht11_data, 1);
    check("busy_after_stuck", busy, 0);
    idle(10);

    // Reset during bit 20: everything clears, no pulse.
    f = rand_frame(1'b1);
    host_start(rc);
    sensor_frame(f, 19, -1, 1'b0);
    idle(20);

    // Next start after the abort completes normally.
    f = 40'h37_00_19_00_50;
    sb.push_back(frame_expect(f));
    host_start(rc);
    sensor_frame(f, -1, -1, 1'b0);
    idle(20);

    // Reset while the start pulse is being driven.
    start = 1'b1;
    idle(1);
    start = 1'b0;
    idle(10);
    check("line_driven_in_start_low", dht11_data, 0);
    reset_n = 1'b0;
    #1;
    check("line_freed_by_reset", dht11_data, 1);
    check("busy_cleared_by_reset", busy, 0);
    model_value = 16'h0000;
    idle(3);
    reset_n = 1'b1;
    idle(5);

    // Start re-pulsed mid-frame and again in the valid cycle.
    f = rand_frame(1'b1);
    sb.push_back(frame_expect(f));
    host_start(rc);
    sensor_frame(f, -1, int'($urandom_range(30, 2)), 1'b1);
    idle(20);

    for (int n = 0; n < 4; n++) begin
      f = rand_frame($urandom_range(1, 0) == 1);
      sb.push_back(frame_expect(f));
      host_start(rc);
      sensor_frame(f, -1, -1, 1'b0);
      idle(int'($urandom_range(40, 10)));
    end

    idle(20);
    check("scoreboard_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dht11_frame_reader.md
DHT11_FRAME_READER -- requirements
Module: dht11_frame_reader

Interface
REQ-001 SHALL have parameter CLK_HZ, default 100_000_000, system clock frequency used to derive a 1 us tick.
REQ-002 SHALL have parameter START_LOW_US, default 18_000, length of the host start-low pulse.
REQ-003 SHALL have parameter TIMEOUT_US, default 200, maximum wait in any sensor-driven phase.
REQ-004 SHALL have parameter BIT_THRESH_US, default 50; a bit's high phase longer than this value decodes as 1.
REQ-005 SHALL have port clk  input  1  system clock; the only clock.
REQ-006 SHALL have port reset_n  input  1  asynchronous active-low reset.
REQ-007 SHALL have port start  input  1  single-cycle request to read one frame; ignored while busy.
REQ-008 SHALL have port dht11_data  inout  1  open-drain sensor line; the block drives only 0 or Z.
REQ-009 SHALL have port busy  output  1  high from an accepted start until valid or error.
REQ-010 SHALL have port valid  output  1  single-cycle pulse; outputs updated with a good frame.
REQ-011 SHALL have port error  output  1  single-cycle pulse; frame aborted.
REQ-012 SHALL have port err_code  output  2  cause: 01 timeout, 10 checksum, 11 line stuck low at start; holds until the next error.
REQ-013 SHALL have port humidity  output  8  integer RH byte of the last good frame.
REQ-014 SHALL have port temperature  output  8  integer temperature byte of the last good frame.
REQ-015 SHALL have port value  output  16  {humidity, temperature}, formatted for the 4-digit FND path.

Function
REQ-016 SHALL sample dht11_data through a 2-flop synchronizer; edges are detected on the synchronized signal.
REQ-017 SHALL advance all protocol timing on a 1 us tick; the tick is high one clk in every CLK_HZ/1_000_000 clocks.
REQ-018 SHALL implement states IDLE, START_LOW, RELEASE, RESP_LOW, RESP_HIGH, BIT_LOW, BIT_HIGH, CHECK.
REQ-019 SHALL transition IDLE -> START_LOW on start, but only if the synchronized line is 1; a line at 0 pulses error with code 11 and stays in IDLE.
REQ-020 SHALL drive the line 0 in START_LOW for START_LOW_US ticks, then release it (Z) and enter RELEASE.
REQ-021 SHALL, in RELEASE, wait for a falling edge -> RESP_LOW.
REQ-022 SHALL, in RESP_LOW, wait for a rising edge -> RESP_HIGH.
REQ-023 SHALL, in RESP_HIGH, wait for a falling edge -> BIT_LOW.
REQ-024 SHALL, in BIT_LOW, wait for a rising edge -> BIT_HIGH, and clear the microsecond counter.
REQ-025 SHALL, in BIT_HIGH on a falling edge, shift in bit = (count > BIT_THRESH_US) MSB-first into a 40-bit register; after bit 40 go to CHECK, else to BIT_LOW.
REQ-026 SHALL treat the 40th bit's high phase as ending on its falling edge, or on a return high after >= TIMEOUT_US; either is accepted.
REQ-027 SHALL, in any of RELEASE..BIT_HIGH with no edge for TIMEOUT_US ticks, pulse error with code 01, release the line, and go to IDLE.
REQ-028 SHALL, in CHECK, compute the checksum as the sum of bytes 4..1, mod 256, compared with byte 0.
REQ-029 SHALL, in CHECK on a match, load humidity = byte 4 and temperature = byte 2, pulse valid, and go to IDLE.
REQ-030 SHALL, in CHECK on a mismatch, pulse error with code 10, leave the outputs unchanged, and go to IDLE.
REQ-031 SHALL produce valid or error exactly 1 clk after CHECK is entered; the two pulses are never both high.
REQ-032 SHALL ignore start asserted in the same cycle that valid or error pulses; it must be re-asserted once busy is low.
REQ-033 SHALL never drive the line except in START_LOW.

Reset
REQ-034 SHALL, on reset_n low, immediately force the state to IDLE, the line to Z, and busy, valid and error to 0.
REQ-035 SHALL, on reset_n low, force err_code, humidity, temperature, value and all counters to 0.
REQ-036 SHALL abort a frame on reset asserted mid-frame, with no valid or error pulse.

Configuration
REQ-037 SHALL compile the checksum check in when DHT11_CHECKSUM_EN is defined: behaviour per REQ-028..030.
REQ-038 SHALL, when DHT11_CHECKSUM_EN is undefined, skip the compare in CHECK and always produce valid; err_code 10 is never produced.

Structure
REQ-039 SHALL place the state enumeration, the err_code constants, and the DHT11 default timing constants in a shared package, dht11_pkg.
REQ-040 SHALL implement the tick divider as a separate sub-module, usec_tick, with ports clk, reset_n and tick.

Verification
REQ-041 SHALL cover: CLK_HZ=1_000_000, sensor model sends 0x37,0x00,0x19,0x00,0x50 -> valid one clk after the 40th bit, value=16'h3719.
REQ-042 SHALL cover: same frame with checksum byte 0x51 and macro defined -> error, err_code=10, value holds its previous contents; with the macro undefined -> valid, value=16'h3719.
REQ-043 SHALL cover: sensor never answers after release -> error with err_code=01 exactly TIMEOUT_US ticks after RELEASE is entered; busy then 0.
REQ-044 SHALL cover: line held 0 when start is pulsed -> error, err_code=11, line never driven.
REQ-045 SHALL cover: reset_n pulled low during bit 20 -> line Z and all outputs 0 within the same cycle; no valid or error pulse; the next start completes normally.
REQ-046 SHALL cover: start repulsed while busy -> ignored; exactly one valid per accepted start.
